// File: rtl/leglite_pkg.sv
// Shared LEG-lite definitions: opcodes, instruction field positions and
// the fetch/decode sequencer state type.
package leglite_pkg;

   localparam logic [3:0] OP_NOP = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_LDR = 4'b0100;
   localparam logic [3:0] OP_STR = 4'b0101;
   localparam logic [3:0] OP_B   = 4'b1010;
   localparam logic [3:0] OP_CBZ = 4'b1011;

   localparam int unsigned OpcMsb   = 15;
   localparam int unsigned OpcLsb   = 12;
   localparam int unsigned ConstMsb = 9;
   localparam int unsigned ConstLsb = 3;
   localparam int unsigned RegMsb   = 2;
   localparam int unsigned RegLsb   = 0;

   typedef enum logic [1:0] {
      StIdle,
      StFetch,
      StExec,
      StErr
   } fdu_state_e;

endpackage

// File: rtl/fetch_decode_unit_if.sv
// Instruction-memory req/ack port: the fetch unit is master, memory is slave.
interface fetch_decode_unit_if;

   logic [15:0] imem_addr;
   logic        imem_req;
   logic        imem_ack;
   logic [15:0] imem_rdata;

   modport master (
      output imem_addr,
      output imem_req,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_addr,
      input  imem_req,
      output imem_ack,
      output imem_rdata
   );

endinterface

// File: rtl/fetch_decode_unit_instr_decoder.sv
// Combinational decode of the instruction register: CBZ detect, sign-extended
// branch constant and tested register.
module instr_decoder
   import leglite_pkg::*;
#(
   parameter logic [3:0] OP_CBZ = leglite_pkg::OP_CBZ
) (
   input  logic [15:0] ir_i,
   output logic        branch_raw_o,
   output logic [15:0] signext_o,
   output logic [2:0]  reg_sel_o
);

   logic [6:0] imm;
   logic       unused_ir;

   assign imm          = ir_i[ConstMsb:ConstLsb];
   assign signext_o    = {{9{imm[6]}}, imm};
   assign reg_sel_o    = ir_i[RegMsb:RegLsb];
   assign branch_raw_o = (ir_i[OpcMsb:OpcLsb] == OP_CBZ);

   // IR[11:10] carry no meaning for CBZ.
   assign unused_ir = ^ir_i[11:10];

endmodule

// File: rtl/fetch_decode_unit.sv
// Fetches one instruction per PC over a req/ack port, decodes CBZ and pulses
// pc_enable once per retired instruction; flags (sticky) fetch timeouts.
module fetch_decode_unit
   import leglite_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 8,
   parameter logic [3:0]  OP_CBZ   = leglite_pkg::OP_CBZ
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [15:0]                pc,
   fetch_decode_unit_if.master        imem,
   output logic                       pc_enable,
   output logic                       branch,
   output logic [15:0]                signext,
   output logic [2:0]                 reg_sel,
   output logic                       fetch_err,
   output logic [15:0]                instr_count
);

   localparam logic [7:0] WaitLast = 8'(MAX_WAIT - 1);

   fdu_state_e  state_q, state_d;
   logic [15:0] ir_q, ir_d;
   logic [7:0]  wait_q, wait_d;
   logic [15:0] addr_q, addr_d;
   logic        err_q, err_d;
   logic [15:0] count_q, count_d;
   logic        branch_raw;

   instr_decoder #(
      .OP_CBZ (OP_CBZ)
   ) u_instr_decoder (
      .ir_i         (ir_q),
      .branch_raw_o (branch_raw),
      .signext_o    (signext),
      .reg_sel_o    (reg_sel)
   );

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      wait_d  = wait_q;
      addr_d  = addr_q;
      err_d   = err_q;
      count_d = count_q;
      unique case (state_q)
         StIdle: state_d = StFetch;
         StFetch: begin
            if (imem.imem_ack) begin
               ir_d    = imem.imem_rdata;
               wait_d  = '0;
               state_d = StExec;
            end else if (wait_q == WaitLast) begin
               state_d = StErr;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         StExec: begin
            count_d = count_q + 16'd1;
            state_d = StFetch;
         end
         StErr: begin
            err_d   = 1'b1;
            wait_d  = '0;
            state_d = StFetch;
         end
         default: state_d = StIdle;
      endcase
      // Address is captured only on entry to FETCH; pc is ignored while waiting.
      if (state_d == StFetch && state_q != StFetch) begin
         addr_d = pc;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         ir_q    <= '0;
         wait_q  <= '0;
         addr_q  <= '0;
         err_q   <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         wait_q  <= wait_d;
         addr_q  <= addr_d;
         err_q   <= err_d;
         count_q <= count_d;
      end
   end

   assign imem.imem_req  = (state_q == StFetch);
   assign imem.imem_addr = addr_q;
   assign pc_enable      = (state_q == StExec);
   assign branch         = pc_enable && branch_raw;
   assign fetch_err      = err_q;
   assign instr_count    = count_q;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Randomised bench for fetch_decode_unit with a behavioural memory/PC model.
module tb_fetch_decode_unit;

   localparam int MaxWait = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] pc = '0;
   logic        pc_enable;
   logic        branch;
   logic [15:0] signext;
   logic [2:0]  reg_sel;
   logic        fetch_err;
   logic [15:0] instr_count;

   int tests_run = 0;
   int tests_failed = 0;

   logic [15:0] model_pc = '0;
   logic [15:0] exp_count = '0;
   logic        exp_err = 1'b0;

   fetch_decode_unit_if imem_if ();

   fetch_decode_unit #(
      .MAX_WAIT (MaxWait),
      .OP_CBZ   (4'b1011)
   ) dut (
      .clock       (clk),
      .reset       (reset),
      .pc          (pc),
      .imem        (imem_if.master),
      .pc_enable   (pc_enable),
      .branch      (branch),
      .signext     (signext),
      .reg_sel     (reg_sel),
      .fetch_err   (fetch_err),
      .instr_count (instr_count)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One instruction from the first FETCH cycle through to the next FETCH cycle.
   task automatic do_instr(input logic [15:0] word, input int delay, input bit alu_zero,
                           input bit spurious);
      int          d;
      int          c;
      int          sx;
      bit          done;
      bit          br_exp;
      logic [15:0] sext_exp;
      logic [2:0]  reg_exp;
      d = delay;
      c = 0;
      done = 0;
      sx = int'(word[9:3]);
      if (sx > 63) sx = sx - 128;
      sext_exp = 16'(sx);
      br_exp = (word[15:12] == 4'b1011);
      reg_exp = word[2:0];
      while (!done) begin
         tests_run++;
         if (imem_if.imem_req !== 1'b1 || imem_if.imem_addr !== model_pc || pc_enable !== 1'b0)
         begin
            tests_failed++;
            $display("FAIL fetch: req=%b addr=%h pc_en=%b, want req=1 addr=%h pc_en=0",
                     imem_if.imem_req, imem_if.imem_addr, pc_enable, model_pc);
         end
         if (c == d) begin
            imem_if.imem_ack = 1'b1;
            imem_if.imem_rdata = word;
            pc = model_pc;
            @(negedge clk);
            imem_if.imem_ack = 1'b0;
            done = 1;
         end else if (c == MaxWait - 1) begin
            pc = model_pc;
            @(negedge clk);
            tests_run++;
            if (imem_if.imem_req !== 1'b0 || pc_enable !== 1'b0 || fetch_err !== exp_err) begin
               tests_failed++;
               $display("FAIL err_cycle: req=%b pc_en=%b err=%b, want req=0 pc_en=0 err=%b",
                        imem_if.imem_req, pc_enable, fetch_err, exp_err);
            end
            @(negedge clk);
            exp_err = 1'b1;
            tests_run++;
            if (fetch_err !== 1'b1) begin
               tests_failed++;
               $display("FAIL fetch_err_set: got %b want 1", fetch_err);
            end
            d = d - MaxWait;
            if (d < 0) d = 0;
            c = 0;
         end else begin
            pc = model_pc ^ 16'($urandom);
            @(negedge clk);
            c++;
         end
      end
      tests_run++;
      if (pc_enable !== 1'b1 || imem_if.imem_req !== 1'b0 || branch !== br_exp ||
          signext !== sext_exp || reg_sel !== reg_exp || fetch_err !== exp_err ||
          instr_count !== exp_count) begin
         tests_failed++;
         $display("FAIL exec: pc_en=%b req=%b br=%b sx=%h reg=%0d err=%b cnt=%0d, want 1 0 %b %h %0d %b %0d",
                  pc_enable, imem_if.imem_req, branch, signext, reg_sel, fetch_err, instr_count,
                  br_exp, sext_exp, reg_exp, exp_err, exp_count);
      end
      // PC logic reacts to pc_enable within the EXEC cycle.
      if (br_exp && alu_zero) model_pc = model_pc + (sext_exp << 1);
      else model_pc = model_pc + 16'd2;
      pc = model_pc;
      exp_count = exp_count + 16'd1;
      if (spurious) begin
         imem_if.imem_ack = 1'b1;
         imem_if.imem_rdata = ~word;
      end
      @(negedge clk);
      imem_if.imem_ack = 1'b0;
      tests_run++;
      if (instr_count !== exp_count || signext !== sext_exp || reg_sel !== reg_exp ||
          branch !== 1'b0 || pc_enable !== 1'b0) begin
         tests_failed++;
         $display("FAIL post_exec: cnt=%0d sx=%h reg=%0d br=%b pc_en=%b, want %0d %h %0d 0 0",
                  instr_count, signext, reg_sel, branch, pc_enable, exp_count, sext_exp, reg_exp);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      pc = 16'h1234;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         tests_run++;
         if ({imem_if.imem_req, imem_if.imem_addr, pc_enable, branch, signext, reg_sel,
              fetch_err, instr_count} !== '0) begin
            tests_failed++;
            $display("FAIL reset: req=%b addr=%h pc_en=%b br=%b sx=%h reg=%0d err=%b cnt=%0d, want all 0",
                     imem_if.imem_req, imem_if.imem_addr, pc_enable, branch, signext, reg_sel,
                     fetch_err, instr_count);
         end
      end
      reset = 1'b0;
      model_pc = '0;
      pc = model_pc;
      exp_count = '0;
      exp_err = 1'b0;
      tests_run++;
      if (imem_if.imem_req !== 1'b0 || pc_enable !== 1'b0) begin
         tests_failed++;
         $display("FAIL bubble: req=%b pc_en=%b want 0 0", imem_if.imem_req, pc_enable);
      end
      @(negedge clk);
   endtask

   task automatic test_stream_zero();
      for (int i = 0; i < 3; i++) do_instr(16'h0000, 0, 1'b0, 1'b0);
      tests_run++;
      if (instr_count !== 16'd3) begin
         tests_failed++;
         $display("FAIL stream_count: got %0d want 3", instr_count);
      end
   endtask

   task automatic test_cbz_fwd();
      logic [15:0] start;
      start = model_pc;
      do_instr(16'hB030, 0, 1'b1, 1'b0);
      tests_run++;
      if (imem_if.imem_addr !== start + 16'd12) begin
         tests_failed++;
         $display("FAIL cbz_fwd_addr: got %h want %h", imem_if.imem_addr, start + 16'd12);
      end
   endtask

   task automatic test_cbz_back();
      logic [15:0] start;
      start = model_pc;
      do_instr(16'hB3E8, 0, 1'b1, 1'b0);
      tests_run++;
      if (imem_if.imem_addr !== start - 16'd6) begin
         tests_failed++;
         $display("FAIL cbz_back_addr: got %h want %h", imem_if.imem_addr, start - 16'd6);
      end
   endtask

   task automatic test_delayed_ack();
      do_instr(16'h1234, 3, 1'b0, 1'b0);
   endtask

   task automatic test_timeout();
      do_instr(16'hB008, MaxWait + 1, 1'b1, 1'b0);
      do_instr(16'h2001, 0, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid_fetch();
      do_instr(16'h0042, 0, 1'b0, 1'b0);
      imem_if.imem_ack = 1'b1;
      imem_if.imem_rdata = 16'hB3E8;
      reset = 1'b1;
      @(negedge clk);
      imem_if.imem_ack = 1'b0;
      tests_run++;
      if (imem_if.imem_req !== 1'b0 || instr_count !== 16'd0 || signext !== 16'd0 ||
          reg_sel !== 3'd0 || pc_enable !== 1'b0 || fetch_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_mid: req=%b cnt=%0d sx=%h reg=%0d pc_en=%b err=%b, want all 0",
                  imem_if.imem_req, instr_count, signext, reg_sel, pc_enable, fetch_err);
      end
      reset = 1'b0;
      model_pc = 16'($urandom) & 16'hFFFE;
      pc = model_pc;
      exp_count = '0;
      exp_err = 1'b0;
      @(negedge clk);
      do_instr(16'($urandom), 0, 1'b0, 1'b1);
   endtask

   task automatic test_random();
      logic [15:0] w;
      for (int i = 0; i < 40; i++) begin
         w = 16'($urandom);
         if ($urandom_range(0, 1) == 1) w[15:12] = 4'b1011;
         do_instr(w, int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      imem_if.imem_ack = 1'b0;
      imem_if.imem_rdata = '0;
      test_reset();
      test_stream_zero();
      test_cbz_fwd();
      test_cbz_back();
      test_delayed_ack();
      test_timeout();
      test_reset_mid_fetch();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
